// File: rtl/tiny_fpga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tiny_fpga_pkg
//  Description : Types and constants shared by the tiny_fpga_2x2 fabric and
//                its configuration loader.
//                t_cfg_loader_state - loader sequencing states
//                CLB_COUNT_DEFAULT  - CLBs in the 2x2 fabric
//  Revision    : 1.0 - initial release
// ============================================================================
package tiny_fpga_pkg;

    localparam int CLB_COUNT_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CFG_PULSE  = 3'd1,
        ST_STREAM     = 3'd2,
        ST_WAIT_READY = 3'd3,
        ST_RUN        = 3'd4
    } t_cfg_loader_state;

endpackage : tiny_fpga_pkg
`default_nettype wire

// File: rtl/axi_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_stream_if
//  Description : Minimal AXI-stream bundle (tvalid/tready/tdata/tlast).
//                master: drives tvalid/tdata/tlast, samples tready
//                slave : the reverse
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_stream_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface : axi_stream_if
`default_nettype wire

// File: rtl/cfg_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_word_packer
//  Description : Packs bytes LSB-first into DATA_WIDTH words and presents
//                them on a valid/ready output register.
//  Ports       : clk, rst      clock, synchronous active-high reset
//                clear         zero the byte counter (start of a new load)
//                enable        allow byte acceptance
//                in_valid/in_data/in_ready   byte side handshake
//                in_last       tlast value captured with the completed word
//                out_valid/out_ready/out_data/out_last   word side
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_word_packer #(
    parameter int DATA_WIDTH = 16
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int BPW  = DATA_WIDTH / 8;
    localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BC_W-1:0] c_BYTE_LAST = BC_W'(BPW - 1);

    logic [BC_W-1:0]       r_byte_cnt;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_complete;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_xfer;

    assign w_complete = (r_byte_cnt == c_BYTE_LAST);
    // Registered terms only: a completing byte waits until the output
    // register is empty, so tready never reaches in_ready combinationally.
    assign in_ready   = enable && !(r_valid && w_complete);
    assign w_accept   = in_valid && in_ready;
    assign w_load     = w_accept && w_complete;
    assign w_xfer     = r_valid && out_ready;

    generate
        if (BPW > 1) begin : g_wide
            logic [DATA_WIDTH-9:0] r_acc;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (w_accept && !w_complete) begin
                    for (int b = 0; b < BPW - 1; b++) begin
                        if (r_byte_cnt == BC_W'(b)) begin
                            r_acc[8*b +: 8] <= in_data;
                        end
                    end
                end
            end

            assign w_word = {in_data, r_acc};
        end else begin : g_narrow
            assign w_word = in_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_last     <= 1'b0;
        end else begin
            if (clear) begin
                r_byte_cnt <= '0;
            end else if (w_accept) begin
                r_byte_cnt <= w_complete ? '0 : r_byte_cnt + 1'b1;
            end

            // A reload in the same cycle as a transfer keeps valid high.
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= w_word;
                r_last  <= in_last;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_last  = r_last;

endmodule : cfg_word_packer
`default_nettype wire

// File: rtl/tiny_fpga_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tiny_fpga_cfg_loader
//  Description : Configuration sequencer for the 2x2 fabric. Takes a byte
//                serial bitstream from the pins, packs it into fabric words,
//                streams it with tlast per CLB, waits for fab_cfg_ready and
//                then gates fab_run on the host command.
//  Ports       : clk, rst                 clock, synchronous active-high reset
//                host_start/host_run      configure pulse / run level
//                host_valid/host_data/host_ready   byte input handshake
//                busy, done, error        status (done/error sticky)
//                fab_cfg                  one-cycle config start pulse
//                fab_bitstream            config word stream (master)
//                fab_cfg_ready            fabric fully configured
//                fab_run                  fabric run enable
//  Revision    : 1.0 - initial release
// ============================================================================
module tiny_fpga_cfg_loader
    import tiny_fpga_pkg::*;
#(
    parameter int BITSTREAM_DATA_WIDTH = 16,
    parameter int CLB_COUNT            = CLB_COUNT_DEFAULT,
    parameter int WORDS_PER_CLB        = 2,
    parameter int TIMEOUT_CYCLES       = 64
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         host_start,
    input  logic         host_run,
    input  logic         host_valid,
    input  logic [7:0]   host_data,
    output logic         host_ready,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic         fab_cfg,
    axi_stream_if.master fab_bitstream,
    input  logic         fab_cfg_ready,
    output logic         fab_run
);

    localparam int WC_W  = (WORDS_PER_CLB  > 1) ? $clog2(WORDS_PER_CLB)  : 1;
    localparam int CC_W  = (CLB_COUNT      > 1) ? $clog2(CLB_COUNT)      : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WC_W-1:0]  c_WORD_LAST = WC_W'(WORDS_PER_CLB - 1);
    localparam logic [CC_W-1:0]  c_CLB_LAST  = CC_W'(CLB_COUNT - 1);
    localparam logic [TMO_W-1:0] c_TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    t_cfg_loader_state r_state;
    t_cfg_loader_state w_state_nxt;

    logic [WC_W-1:0]  r_word_cnt;
    logic [CC_W-1:0]  r_clb_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_done;
    logic             r_error;
    logic             r_fab_run;

    logic                            w_tvalid;
    logic                            w_tlast;
    logic [BITSTREAM_DATA_WIDTH-1:0] w_tdata;
    logic                            w_xfer;

    assign w_xfer = w_tvalid && fab_bitstream.tready;

    cfg_word_packer #(
        .DATA_WIDTH (BITSTREAM_DATA_WIDTH)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (r_state == ST_CFG_PULSE),
        .enable    (r_state == ST_STREAM),
        .in_valid  (host_valid),
        .in_data   (host_data),
        .in_ready  (host_ready),
        .in_last   (r_word_cnt == c_WORD_LAST),
        .out_valid (w_tvalid),
        .out_ready (fab_bitstream.tready),
        .out_data  (w_tdata),
        .out_last  (w_tlast)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (host_start) begin
                    w_state_nxt = ST_CFG_PULSE;
                end else if (host_run && r_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_CFG_PULSE: begin
                w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_xfer && w_tlast && (r_clb_cnt == c_CLB_LAST)) begin
                    w_state_nxt = ST_WAIT_READY;
                end
            end
            ST_WAIT_READY: begin
                // cfg_ready is tested first so it wins over a coincident timeout.
                if (fab_cfg_ready || (r_tmo_cnt == c_TMO_LAST)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (host_start) begin
                    w_state_nxt = ST_CFG_PULSE;
                end else if (!host_run) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_word_cnt <= '0;
            r_clb_cnt  <= '0;
            r_tmo_cnt  <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_fab_run  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_fab_run <= (w_state_nxt == ST_RUN);

            // Only IDLE/RUN can move to CFG_PULSE: that is a new load.
            if (w_state_nxt == ST_CFG_PULSE) begin
                r_done  <= 1'b0;
                r_error <= 1'b0;
            end

            case (r_state)
                ST_CFG_PULSE: begin
                    r_word_cnt <= '0;
                    r_clb_cnt  <= '0;
                    r_tmo_cnt  <= '0;
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        if (w_tlast) begin
                            r_word_cnt <= '0;
                            r_clb_cnt  <= (r_clb_cnt == c_CLB_LAST) ? '0 : r_clb_cnt + 1'b1;
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT_READY: begin
                    if (fab_cfg_ready) begin
                        r_done <= 1'b1;
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_error <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (r_state == ST_CFG_PULSE) || (r_state == ST_STREAM) ||
                     (r_state == ST_WAIT_READY);
    assign done    = r_done;
    assign error   = r_error;
    assign fab_cfg = (r_state == ST_CFG_PULSE);
    assign fab_run = r_fab_run;

    assign fab_bitstream.tvalid = w_tvalid;
    assign fab_bitstream.tdata  = w_tdata;
    assign fab_bitstream.tlast  = w_tlast;

endmodule : tiny_fpga_cfg_loader
`default_nettype wire

// File: tb/tb_tiny_fpga_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tiny_fpga_cfg_loader
//  Description : Self-checking bench for tiny_fpga_cfg_loader. Expected words
//                are packed from the bytes the bench sends and queued; the
//                stream monitor pops and compares them on each transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tiny_fpga_cfg_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       host_start, host_run, host_valid;
    logic [7:0] host_data;
    logic       host_ready, busy, done, error, fab_cfg, fab_cfg_ready, fab_run;

    axi_stream_if #(.DATA_WIDTH(16)) fab_bs ();

    tiny_fpga_cfg_loader #(
        .BITSTREAM_DATA_WIDTH (16),
        .CLB_COUNT            (4),
        .WORDS_PER_CLB        (2),
        .TIMEOUT_CYCLES       (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host_start    (host_start),
        .host_run      (host_run),
        .host_valid    (host_valid),
        .host_data     (host_data),
        .host_ready    (host_ready),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .fab_cfg       (fab_cfg),
        .fab_bitstream (fab_bs),
        .fab_cfg_ready (fab_cfg_ready),
        .fab_run       (fab_run)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: {tlast, tdata}
    logic [16:0] exp_q[$];
    logic [16:0] e;
    logic [15:0] mdl_word;
    int          mdl_bcnt;
    int          mdl_widx;
    int          n_words;
    int          last_xfer_cyc;

    // Backpressure control and hold tracking
    bit          bp_mode = 0;
    int          bp_left = 0;
    bit          held_valid = 0;
    logic [15:0] held_data;

    always @(negedge clk) begin
        if (rst) begin
            fab_bs.tready = 1'b1;
            held_valid    = 0;
        end else begin
            if (bp_mode && fab_bs.tvalid && fab_bs.tdata == 16'h0504 && bp_left > 0) begin
                fab_bs.tready = 1'b0;
                // From the second stall onward the completing byte 0x07 must be refused.
                if (bp_left <= 4) check("bp_host_ready", host_ready, 0);
                bp_left--;
            end else begin
                fab_bs.tready = 1'b1;
            end

            if (fab_bs.tvalid) begin
                if (held_valid) check("hold_tdata", fab_bs.tdata, held_data);
                if (fab_bs.tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", fab_bs.tdata, 32'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        check("tdata", fab_bs.tdata, e[15:0]);
                        check("tlast", fab_bs.tlast, e[16]);
                    end
                    n_words++;
                    if (fab_bs.tlast) last_xfer_cyc = cyc + 1;
                    held_valid = 0;
                end else begin
                    held_valid = 1;
                    held_data  = fab_bs.tdata;
                end
            end else begin
                held_valid = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard      = 0;
        host_valid = 1'b1;
        host_data  = b;
        @(negedge clk);
        while (!host_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!host_ready) check("byte_accept_timeout", 0, 1);
        @(posedge clk); #1;
        host_valid = 1'b0;
        if (host_ready || guard < 200) begin
            mdl_word[8*mdl_bcnt +: 8] = b;
            mdl_bcnt++;
            if (mdl_bcnt == 2) begin
                exp_q.push_back({(mdl_widx % 2 == 1), mdl_word});
                mdl_widx++;
                mdl_bcnt = 0;
            end
        end
    endtask

    task automatic start_cfg(input bit from_run);
        exp_q.delete();
        mdl_bcnt   = 0;
        mdl_widx   = 0;
        n_words    = 0;
        host_start = 1'b1;
        @(posedge clk); #1;
        host_start = 1'b0;
        check("cfg_pulse_hi", fab_cfg, 1);
        check("cfg_busy", busy, 1);
        check("cfg_done_clr", done, 0);
        if (from_run) check("reconf_run_off", fab_run, 0);
        @(posedge clk); #1;
        check("cfg_pulse_lo", fab_cfg, 0);
        check("stream_ready", host_ready, 1);
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) send_byte(8'(i));
    endtask

    task automatic finish_ok();
        int guard;
        repeat (3) @(posedge clk);
        #1;
        fab_cfg_ready = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!done && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("done", done, 1);
        check("done_busy", busy, 0);
        check("done_error", error, 0);
        check("words_seen", n_words, 8);
        check("queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        fab_cfg_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        host_start    = 1'b0;
        host_run      = 1'b0;
        host_valid    = 1'b0;
        host_data     = 8'h00;
        fab_cfg_ready = 1'b0;
        fab_bs.tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_host_ready", host_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_fab_cfg", fab_cfg, 0);
        check("rst_fab_run", fab_run, 0);
        check("rst_tvalid", fab_bs.tvalid, 0);
        check("rst_tdata", fab_bs.tdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Run requested before any configuration: ignored
        host_run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("run_unconfigured", fab_run, 0);
        end
        host_run = 1'b0;
        @(posedge clk); #1;

        // Nominal load
        start_cfg(0);
        send_bytes(16);
        finish_ok();

        // Run gating after load
        host_run = 1'b1;
        @(posedge clk); #1;
        check("run_on", fab_run, 1);
        check("run_busy", busy, 0);

        // Reconfigure from RUN, with backpressure on word 2
        bp_mode = 1;
        bp_left = 5;
        start_cfg(1);
        host_run = 1'b0;
        send_bytes(16);
        finish_ok();
        check("bp_consumed", bp_left, 0);
        bp_mode = 0;

        host_run = 1'b1;
        @(posedge clk); #1;
        check("run_on2", fab_run, 1);
        host_run = 1'b0;
        @(posedge clk); #1;
        check("run_off", fab_run, 0);

        // Timeout with fab_cfg_ready tied low
        start_cfg(0);
        send_bytes(16);
        begin
            int guard;
            guard = 0;
            @(negedge clk);
            while (!error && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            check("tmo_error", error, 1);
            check("tmo_cycles", cyc - last_xfer_cyc, 64);
            check("tmo_done", done, 0);
            check("tmo_busy", busy, 0);
            check("tmo_words", n_words, 8);
        end
        @(posedge clk); #1;

        // Reset mid-stream
        start_cfg(0);
        send_bytes(5);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_tvalid", fab_bs.tvalid, 0);
        check("mid_rst_host_ready", host_ready, 0);
        check("mid_rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        start_cfg(0);
        send_bytes(16);
        finish_ok();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_tiny_fpga_cfg_loader
`default_nettype wire
